// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the 8-bit binary to 3-digit BCD converter.
//   bin_t   : unsigned binary operand, 0..255
//   bcd_t   : packed BCD {hundreds[1:0], tens[3:0], units[3:0]}
//   state_t : converter FSM states
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BIN_W  = 8;
    localparam int BCD_W  = 10;
    localparam int N_ITER = 8;

    typedef logic [BIN_W-1:0] bin_t;
    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Double-dabble digit correction: a digit of 5 or more gets 3 added so that
//   the following left shift carries correctly into the next decimal digit.
//   in  : 4-bit BCD digit before correction
//   out : 4-bit corrected digit
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] in,
    output logic [3:0] out
);

    assign out = (in >= 4'd5) ? in + 4'd3 : in;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Converts an 8-bit unsigned value to packed BCD with a valid/ready handshake
//   on both sides.
//
//   Build option BIN2BCD_SINGLE_CYCLE_EN:
//     undefined : iterative double-dabble, one shift per cycle, result 9 cycles
//                 after acceptance.
//     defined   : all 8 iterations unrolled combinationally, result registered
//                 at acceptance and presented 1 cycle later.
//
//   Ports
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     in_valid  : bin_in holds a value to convert
//     in_ready  : converter is idle and will accept a value
//     bin_in    : unsigned binary value, 0..255
//     out_valid : bcd_out holds a completed result
//     out_ready : consumer accepts the result
//     bcd_out   : {hundreds[1:0], tens[3:0], units[3:0]}, registered
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] bin_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] bcd_out
);

`ifdef BIN2BCD_SINGLE_CYCLE_EN
    localparam int N_STAGE = N_ITER;
`else
    localparam int N_STAGE = 1;
`endif

    state_t state;
    bcd_t   first_acc;
    bin_t   first_bin;
    bcd_t   last_acc;

`ifdef BIN2BCD_SINGLE_CYCLE_EN
    // The whole conversion is evaluated straight from the input port.
    assign first_acc = '0;
    assign first_bin = bin_in;
`else
    bcd_t        acc;
    bin_t        sr;
    logic [2:0]  cnt;
    bin_t        last_bin;

    // One stage evaluated per cycle against the working registers.
    assign first_acc = acc;
    assign first_bin = sr;
`endif

    // Chain of double-dabble steps. The hundreds digit needs no correction:
    // before the final shift the partial value is at most 127, so hundreds is
    // at most 1 and can never reach 5.
    for (genvar g = 0; g < N_STAGE; g++) begin : g_stage
        bcd_t       acc_i;
        bcd_t       acc_o;
        bin_t       bin_i;
        bin_t       bin_o;
        logic [3:0] tens_adj;
        logic [3:0] units_adj;

        if (g == 0) begin : g_first
            assign acc_i = first_acc;
            assign bin_i = first_bin;
        end else begin : g_next
            assign acc_i = g_stage[g-1].acc_o;
            assign bin_i = g_stage[g-1].bin_o;
        end

        bcd_add3 u_tens  (.in(acc_i[7:4]), .out(tens_adj));
        bcd_add3 u_units (.in(acc_i[3:0]), .out(units_adj));

        // Shift {hundreds, tens, units, binary} left by one; the bit falling
        // off the top is always zero for 8-bit inputs.
        assign {acc_o, bin_o} = {acc_i[9:8], tens_adj, units_adj, bin_i} << 1;
    end

    assign last_acc = g_stage[N_STAGE-1].acc_o;
`ifndef BIN2BCD_SINGLE_CYCLE_EN
    assign last_bin = g_stage[N_STAGE-1].bin_o;
`endif

    // NOTE: all state lives in this one clocked block and is updated with
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd_out   <= '0;
`ifndef BIN2BCD_SINGLE_CYCLE_EN
            acc       <= '0;
            sr        <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef BIN2BCD_SINGLE_CYCLE_EN
                        bcd_out   <= last_acc;
                        state     <= DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
`else
                        sr        <= bin_in;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= SHIFT;
                        in_ready  <= 1'b0;
`endif
                    end
                end

`ifndef BIN2BCD_SINGLE_CYCLE_EN
                SHIFT: begin
                    acc <= last_acc;
                    sr  <= last_bin;
                    cnt <= cnt + 3'd1;
                    // Counter wraps 7->0 on the eighth shift: publish result.
                    if (cnt == 3'(N_ITER - 1)) begin
                        bcd_out   <= last_acc;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule : bin2bcd_seq
